// File: rtl/bf_core_v2.sv
// bf_core_v2: parametrised 3-bit-opcode tape-machine core with valid/ready
// byte streams, program-end halt and unmatched-bracket error detection.
// Optional feature macro: BF_CORE_V2_SP_BOUNDS_EN (trap on sp over/underflow).
module bf_core_v2 #(
  parameter int unsigned CELL_WIDTH = 8,
  parameter int unsigned SP_WIDTH   = 16,
  parameter int unsigned PC_WIDTH   = 16,
  parameter logic [PC_WIDTH-1:0] PROG_LEN = PC_WIDTH'(16'hFFFF)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic                  tape_we,
  output logic [SP_WIDTH-1:0]   sp,
  input  logic [CELL_WIDTH-1:0] tape_data_read,
  output logic [CELL_WIDTH-1:0] tape_data_write,
  output logic [PC_WIDTH-1:0]   pc,
  input  logic [2:0]            pmem_data_read,
  output logic                  out_valid,
  output logic [CELL_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  input  logic                  in_valid,
  input  logic [CELL_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  halted,
  output logic                  error
);

  localparam int unsigned DEPTH_WIDTH = PC_WIDTH + 1;

  typedef enum logic [2:0] {
    OP_INC   = 3'd0,
    OP_DEC   = 3'd1,
    OP_INCSP = 3'd2,
    OP_DECSP = 3'd3,
    OP_JZ    = 3'd4,
    OP_JNZ   = 3'd5,
    OP_OUT   = 3'd6,
    OP_IN    = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_SKIP      = 3'd4,
    S_OUT_WAIT  = 3'd5,
    S_IN_WAIT   = 3'd6,
    S_HALT      = 3'd7
  } state_e;

  state_e                 state_q, state_d;
  op_e                    op_q, op_d;
  logic [CELL_WIDTH-1:0]  cell_q, cell_d;
  logic [SP_WIDTH-1:0]    sp_tmp_q, sp_tmp_d;
  logic [DEPTH_WIDTH-1:0] depth_q, depth_d;
  logic                   dir_q, dir_d;   // 0 scans right, 1 scans left

  logic [PC_WIDTH-1:0]    pc_d;
  logic [SP_WIDTH-1:0]    sp_d;
  logic                   tape_we_d;
  logic [CELL_WIDTH-1:0]  tape_data_write_d;
  logic                   out_valid_d;
  logic [CELL_WIDTH-1:0]  out_data_d;
  logic                   in_ready_d;
  logic                   halted_d;
  logic                   error_d;

  op_e                    rom_op;
  op_e                    open_op;
  op_e                    close_op;

  // State and registered outputs; synchronous reset clears everything
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q         <= S_FETCH;
      op_q            <= OP_INC;
      cell_q          <= '0;
      sp_tmp_q        <= '0;
      depth_q         <= '0;
      dir_q           <= 1'b0;
      pc              <= '0;
      sp              <= '0;
      tape_we         <= 1'b0;
      tape_data_write <= '0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      in_ready        <= 1'b0;
      halted          <= 1'b0;
      error           <= 1'b0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      cell_q          <= cell_d;
      sp_tmp_q        <= sp_tmp_d;
      depth_q         <= depth_d;
      dir_q           <= dir_d;
      pc              <= pc_d;
      sp              <= sp_d;
      tape_we         <= tape_we_d;
      tape_data_write <= tape_data_write_d;
      out_valid       <= out_valid_d;
      out_data        <= out_data_d;
      in_ready        <= in_ready_d;
      halted          <= halted_d;
      error           <= error_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d           = state_q;
    op_d              = op_q;
    cell_d            = cell_q;
    sp_tmp_d          = sp_tmp_q;
    depth_d           = depth_q;
    dir_d             = dir_q;
    pc_d              = pc;
    sp_d              = sp;
    tape_we_d         = 1'b0;
    tape_data_write_d = tape_data_write;
    out_valid_d       = out_valid;
    out_data_d        = out_data;
    in_ready_d        = in_ready;
    halted_d          = halted;
    error_d           = error;
    rom_op            = op_e'(pmem_data_read);
    // Bracket that deepens the scan vs. the one that closes it
    open_op           = dir_q ? OP_JNZ : OP_JZ;
    close_op          = dir_q ? OP_JZ : OP_JNZ;

    case (state_q)
      S_FETCH: begin
        if (pc == PROG_LEN) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          op_d    = rom_op;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        case (op_q)
          OP_INC, OP_DEC: begin
            cell_d  = tape_data_read;
            state_d = S_EXECUTE;
          end
          OP_INCSP, OP_DECSP: begin
            sp_tmp_d = sp;
            state_d  = S_EXECUTE;
          end
          OP_JZ: begin
            if (tape_data_read != '0) begin
              pc_d    = pc + PC_WIDTH'(1);
              state_d = S_FETCH;
            end else begin
              depth_d = '0;
              dir_d   = 1'b0;
              state_d = S_SKIP;
            end
          end
          OP_JNZ: begin
            if (tape_data_read == '0) begin
              pc_d    = pc + PC_WIDTH'(1);
              state_d = S_FETCH;
            end else begin
              depth_d = '0;
              dir_d   = 1'b1;
              state_d = S_SKIP;
            end
          end
          OP_OUT: begin
            out_data_d  = tape_data_read;
            out_valid_d = 1'b1;
            state_d     = S_OUT_WAIT;
          end
          OP_IN: begin
            in_ready_d = 1'b1;
            state_d    = S_IN_WAIT;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_EXECUTE: begin
        state_d = S_WRITEBACK;
        case (op_q)
          OP_INC: begin
            tape_data_write_d = cell_q + CELL_WIDTH'(1);
            tape_we_d         = 1'b1;
          end
          OP_DEC: begin
            tape_data_write_d = cell_q - CELL_WIDTH'(1);
            tape_we_d         = 1'b1;
          end
          OP_INCSP: begin
`ifdef BF_CORE_V2_SP_BOUNDS_EN
            if (sp_tmp_q == '1) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
              error_d  = 1'b1;
            end else begin
              sp_tmp_d = sp_tmp_q + SP_WIDTH'(1);
            end
`else
            sp_tmp_d = sp_tmp_q + SP_WIDTH'(1);
`endif
          end
          OP_DECSP: begin
`ifdef BF_CORE_V2_SP_BOUNDS_EN
            if (sp_tmp_q == '0) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
              error_d  = 1'b1;
            end else begin
              sp_tmp_d = sp_tmp_q - SP_WIDTH'(1);
            end
`else
            sp_tmp_d = sp_tmp_q - SP_WIDTH'(1);
`endif
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_WRITEBACK: begin
        // tape_we is high during this cycle; the RAM captures it at the edge
        if ((op_q == OP_INCSP) || (op_q == OP_DECSP)) begin
          sp_d = sp_tmp_q;
        end
        pc_d    = pc + PC_WIDTH'(1);
        state_d = S_FETCH;
      end

      S_SKIP: begin
        if (!dir_q && (pc == PROG_LEN)) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          error_d  = 1'b1;
        end else begin
          if (rom_op == open_op) begin
            depth_d = depth_q + DEPTH_WIDTH'(1);
          end else if (rom_op == close_op) begin
            depth_d = depth_q - DEPTH_WIDTH'(1);
          end
          if ((rom_op == close_op) && (depth_q == DEPTH_WIDTH'(1))) begin
            pc_d    = pc + PC_WIDTH'(1);
            state_d = S_FETCH;
          end else if (dir_q) begin
            if (pc == '0) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
              error_d  = 1'b1;
            end else begin
              pc_d = pc - PC_WIDTH'(1);
            end
          end else begin
            pc_d = pc + PC_WIDTH'(1);
          end
        end
      end

      S_OUT_WAIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          pc_d        = pc + PC_WIDTH'(1);
          state_d     = S_FETCH;
        end
      end

      S_IN_WAIT: begin
        if (in_valid) begin
          in_ready_d        = 1'b0;
          tape_we_d         = 1'b1;
          tape_data_write_d = in_data;
          pc_d              = pc + PC_WIDTH'(1);
          state_d           = S_FETCH;
        end
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_bf_core_v2.sv
// Directed testbench for bf_core_v2. Programs are right-aligned in a 16-word
// ROM (PROG_LEN=16) and padded in front with ']' which is a no-op on a zero cell.
module tb_bf_core_v2;

  localparam int unsigned CW      = 8;
  localparam int unsigned SW      = 16;
  localparam int unsigned PW      = 16;
  localparam int unsigned ROM_LEN = 16;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          tape_we;
  logic [SW-1:0] sp;
  logic [CW-1:0] tape_data_read;
  logic [CW-1:0] tape_data_write;
  logic [PW-1:0] pc;
  logic [2:0]    pmem_data_read;
  logic          out_valid;
  logic [CW-1:0] out_data;
  logic          out_ready;
  logic          in_valid;
  logic [CW-1:0] in_data;
  logic          in_ready;
  logic          halted;
  logic          error;

  int checks   = 0;
  int failures = 0;

  logic [CW-1:0] tape [0:65535];
  logic [2:0]    rom  [0:ROM_LEN-1];
  logic          tape_clr;
  int            wr_cnt;
  logic [SW-1:0] wr_addr;
  logic [CW-1:0] wr_data;
  int            out_cnt;
  logic [CW-1:0] out_last;

  bf_core_v2 #(
    .CELL_WIDTH(CW),
    .SP_WIDTH  (SW),
    .PC_WIDTH  (PW),
    .PROG_LEN  (16'd16)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .tape_we        (tape_we),
    .sp             (sp),
    .tape_data_read (tape_data_read),
    .tape_data_write(tape_data_write),
    .pc             (pc),
    .pmem_data_read (pmem_data_read),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .halted         (halted),
    .error          (error)
  );

  always #5 clock = ~clock;

  assign tape_data_read = tape[sp];
  assign pmem_data_read = rom[pc[3:0]];

  // Tape RAM model plus write and output-transfer monitors
  always @(posedge clock) begin
    if (tape_clr) begin
      for (int i = 0; i < 65536; i++) tape[i] <= '0;
      wr_cnt  <= 0;
      wr_addr <= '0;
      wr_data <= '0;
      out_cnt <= 0;
      out_last <= '0;
    end else begin
      if (tape_we) begin
        tape[sp] <= tape_data_write;
        wr_cnt   <= wr_cnt + 1;
        wr_addr  <= sp;
        wr_data  <= tape_data_write;
      end
      if (out_valid && out_ready) begin
        out_cnt  <= out_cnt + 1;
        out_last <= out_data;
      end
    end
  end

  function automatic logic [2:0] enc(input byte c);
    case (c)
      "+":     enc = 3'd0;
      "-":     enc = 3'd1;
      ">":     enc = 3'd2;
      "<":     enc = 3'd3;
      "[":     enc = 3'd4;
      "]":     enc = 3'd5;
      ".":     enc = 3'd6;
      ",":     enc = 3'd7;
      default: enc = 3'd5;
    endcase
  endfunction

  task automatic load_prog(input string s);
    int base;
    base = ROM_LEN - s.len();
    for (int i = 0; i < ROM_LEN; i++) rom[i] = 3'd5;
    for (int i = 0; i < s.len(); i++) rom[base + i] = enc(s.getc(i));
  endtask

  task automatic apply_reset();
    reset_n  = 1'b0;
    tape_clr = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset_n  = 1'b1;
    tape_clr = 1'b0;
  endtask

  task automatic run_to_halt(input string name, input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(posedge clock);
      #1;
      n++;
    end
    checks++;
    if (halted !== 1'b1) begin
      failures++;
      $display("FAIL %s_halt_timeout: halted=%b after %0d cycles, expected 1", name, halted, n);
    end
  endtask

  task automatic test_reset();
    load_prog("+");
    out_ready = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    apply_reset();
    checks++;
    if (pc !== 16'd0 || sp !== 16'd0) begin
      failures++;
      $display("FAIL reset_addr: pc=%0h sp=%0h, expected 0 0", pc, sp);
    end
    checks++;
    if ({tape_we, out_valid, in_ready, halted, error} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: we,ov,ir,h,e=%b, expected 00000",
               {tape_we, out_valid, in_ready, halted, error});
    end
    checks++;
    if (tape_data_write !== 8'h00 || out_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_data: twd=%0h od=%0h, expected 0 0", tape_data_write, out_data);
    end
  endtask

  task automatic test_out_basic();
    int pc_hold;
    int wr_hold;
    load_prog("+++.");
    out_ready = 1'b1;
    apply_reset();
    run_to_halt("out_basic", 500);
    checks++;
    if (out_cnt !== 1 || out_last !== 8'd3) begin
      failures++;
      $display("FAIL out_basic_data: cnt=%0d data=%0h, expected 1 3", out_cnt, out_last);
    end
    checks++;
    if (pc !== 16'd16 || error !== 1'b0) begin
      failures++;
      $display("FAIL out_basic_end: pc=%0d error=%b, expected 16 0", pc, error);
    end
    pc_hold = int'(pc);
    wr_hold = wr_cnt;
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if (int'(pc) !== pc_hold || wr_cnt !== wr_hold || halted !== 1'b1) begin
      failures++;
      $display("FAIL halt_absorb: pc=%0d wr=%0d h=%b, expected %0d %0d 1",
               pc, wr_cnt, halted, pc_hold, wr_hold);
    end
  endtask

  task automatic test_dec_wrap();
    load_prog("-");
    out_ready = 1'b1;
    apply_reset();
    run_to_halt("dec", 500);
    checks++;
    if (wr_cnt !== 1 || wr_addr !== 16'd0 || wr_data !== 8'hFF) begin
      failures++;
      $display("FAIL dec_write: cnt=%0d addr=%0h data=%0h, expected 1 0 ff", wr_cnt, wr_addr, wr_data);
    end
    checks++;
    if (tape[0] !== 8'hFF || pc !== 16'd16) begin
      failures++;
      $display("FAIL dec_end: tape0=%0h pc=%0d, expected ff 16", tape[0], pc);
    end
  endtask

  task automatic test_skip_right();
    load_prog("[+[+]].");
    out_ready = 1'b1;
    apply_reset();
    run_to_halt("skip_right", 500);
    checks++;
    if (wr_cnt !== 0) begin
      failures++;
      $display("FAIL skip_right_writes: got %0d, expected 0", wr_cnt);
    end
    checks++;
    if (out_cnt !== 1 || out_last !== 8'd0 || error !== 1'b0) begin
      failures++;
      $display("FAIL skip_right_out: cnt=%0d data=%0h err=%b, expected 1 0 0", out_cnt, out_last, error);
    end
  endtask

  task automatic test_loop();
    load_prog("++[->+<]>.");
    out_ready = 1'b1;
    apply_reset();
    run_to_halt("loop", 1000);
    checks++;
    if (out_cnt !== 1 || out_last !== 8'd2) begin
      failures++;
      $display("FAIL loop_out: cnt=%0d data=%0h, expected 1 2", out_cnt, out_last);
    end
    checks++;
    if (tape[0] !== 8'd0 || tape[1] !== 8'd2) begin
      failures++;
      $display("FAIL loop_tape: t0=%0h t1=%0h, expected 0 2", tape[0], tape[1]);
    end
    checks++;
    if (wr_cnt !== 6 || error !== 1'b0 || sp !== 16'd1) begin
      failures++;
      $display("FAIL loop_state: wr=%0d err=%b sp=%0d, expected 6 0 1", wr_cnt, error, sp);
    end
  endtask

  task automatic test_out_stall();
    int n;
    load_prog("+.");
    out_ready = 1'b0;
    apply_reset();
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_valid_timeout: out_valid=%b, expected 1", out_valid);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clock);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'd1) begin
        failures++;
        $display("FAIL stall_hold%0d: valid=%b data=%0h, expected 1 1", k, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_cnt !== 1 || pc !== 16'd16) begin
      failures++;
      $display("FAIL stall_accept: valid=%b cnt=%0d pc=%0d, expected 0 1 16", out_valid, out_cnt, pc);
    end

    // Reset arriving while a transfer is pending
    load_prog("+.");
    out_ready = 1'b0;
    apply_reset();
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b0 || pc !== 16'd0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL stall_reset: valid=%b pc=%0d halted=%b, expected 0 0 0", out_valid, pc, halted);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_in();
    int n;
    load_prog(",.");
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    apply_reset();
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL in_ready_timeout: in_ready=%b, expected 1", in_ready);
    end
    @(posedge clock);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL in_accept: in_ready=%b, expected 0", in_ready);
    end
    in_valid = 1'b0;
    run_to_halt("in", 500);
    checks++;
    if (tape[0] !== 8'hA5 || wr_cnt !== 1 || out_last !== 8'hA5) begin
      failures++;
      $display("FAIL in_data: tape0=%0h wr=%0d out=%0h, expected a5 1 a5", tape[0], wr_cnt, out_last);
    end
  endtask

  task automatic test_sp_bound();
    load_prog("<");
    out_ready = 1'b1;
    apply_reset();
    run_to_halt("sp_bound", 500);
`ifdef BF_CORE_V2_SP_BOUNDS_EN
    checks++;
    if (error !== 1'b1 || sp !== 16'd0 || pc !== 16'd15) begin
      failures++;
      $display("FAIL sp_trap: err=%b sp=%0h pc=%0d, expected 1 0 15", error, sp, pc);
    end
`else
    checks++;
    if (error !== 1'b0 || sp !== 16'hFFFF || pc !== 16'd16) begin
      failures++;
      $display("FAIL sp_wrap: err=%b sp=%0h pc=%0d, expected 0 ffff 16", error, sp, pc);
    end
`endif
  endtask

  task automatic test_unmatched();
    load_prog("[");
    out_ready = 1'b1;
    apply_reset();
    run_to_halt("unmatched_right", 500);
    checks++;
    if (error !== 1'b1 || pc !== 16'd16) begin
      failures++;
      $display("FAIL unmatched_right: err=%b pc=%0d, expected 1 16", error, pc);
    end

    load_prog("+]");
    apply_reset();
    run_to_halt("unmatched_left", 500);
    checks++;
    if (error !== 1'b1 || pc !== 16'd0 || wr_cnt !== 1) begin
      failures++;
      $display("FAIL unmatched_left: err=%b pc=%0d wr=%0d, expected 1 0 1", error, pc, wr_cnt);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    tape_clr  = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    test_reset();
    test_out_basic();
    test_dec_wrap();
    test_skip_right();
    test_loop();
    test_out_stall();
    test_in();
    test_sp_bound();
    test_unmatched();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
